// File: rtl/spi_reg_slave_if.sv
// Bus bundle for spi_reg_slave: serial SPI pins plus the local register port.
interface spi_reg_slave_if;
   logic       i_sclk;
   logic       i_csn;
   logic       i_mosi;
   logic       o_miso;
   logic       o_miso_oe;
   logic [3:0] i_address;
   logic [7:0] i_data;
   logic       i_wr;
   logic       i_rd;
   logic [7:0] o_data;
   logic       o_spi_wr;
   logic [3:0] o_spi_wr_addr;

   modport slave (
      input  i_sclk, i_csn, i_mosi, i_address, i_data, i_wr, i_rd,
      output o_miso, o_miso_oe, o_data, o_spi_wr, o_spi_wr_addr
   );

   modport master (
      output i_sclk, i_csn, i_mosi, i_address, i_data, i_wr, i_rd,
      input  o_miso, o_miso_oe, o_data, o_spi_wr, o_spi_wr_addr
   );
endinterface

// File: rtl/spi_reg_slave.sv
// SPI (CPOL=1/CPHA=1) slave onto a 16 x 8 register file with a local read/write port.
// state  | meaning
// S_IDLE | deselected, waiting for csn falling
// S_CMD  | shifting in the command byte
// S_DATA | shifting data in (write) and out on miso (read)
// S_DONE | frame complete, sclk ignored until csn rises
module spi_reg_slave #(
   parameter int OVS_MIN   = 8,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic           i_ck,
   input  logic           i_rstn,
   spi_reg_slave_if.slave bus
);

   // Synchronizer plus edge compare costs three cycles; each sclk level must outlast that.
   if (OVS_MIN < 4) begin : g_ovs_check
      $error("spi_reg_slave: OVS_MIN must be at least 4");
   end

   typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

   state_t     state_q, state_d;

   logic       sclk_s1, sclk_s2, sclk_s3;
   logic       csn_s1, csn_s2, csn_s3;
   logic       mosi_s1, mosi_s2;
   logic       sclk_rise, sclk_fall, csn_fall;

   logic [2:0] bit_cnt;
   logic [6:0] rx_shift;
   logic [7:0] tx_shift;
   logic       cmd_rw;
   logic [3:0] cmd_idx;
   logic       miso_q;
   logic       oe_q;
   logic [7:0] regs [16];
   logic [7:0] data_q;
   logic       spi_wr_q;
   logic [3:0] spi_wr_addr_q;

   logic       clear, shift_en, cmd_done, data_done, tx_en, spi_wr;
   logic [7:0] rx_msb, rx_byte, rd_word, tx_load;

   function automatic logic [7:0] rev8(input logic [7:0] v);
      logic [7:0] r;
      for (int k = 0; k < 8; k++) r[k] = v[7-k];
      return r;
   endfunction

   always_ff @(posedge i_ck or negedge i_rstn) begin
      if (!i_rstn) begin
         sclk_s1 <= 1'b1;
         sclk_s2 <= 1'b1;
         sclk_s3 <= 1'b1;
         csn_s1  <= 1'b1;
         csn_s2  <= 1'b1;
         csn_s3  <= 1'b1;
         mosi_s1 <= 1'b0;
         mosi_s2 <= 1'b0;
      end else begin
         sclk_s1 <= bus.i_sclk;
         sclk_s2 <= sclk_s1;
         sclk_s3 <= sclk_s2;
         csn_s1  <= bus.i_csn;
         csn_s2  <= csn_s1;
         csn_s3  <= csn_s2;
         mosi_s1 <= bus.i_mosi;
         mosi_s2 <= mosi_s1;
      end
   end

   assign sclk_rise = sclk_s2 & ~sclk_s3;
   assign sclk_fall = ~sclk_s2 & sclk_s3;
   assign csn_fall  = ~csn_s2 & csn_s3;

   // Shifting is always MSB-first internally; bit order is fixed up at the serial boundary.
   assign rx_msb  = {rx_shift, mosi_s2};
   assign rx_byte = LSB_FIRST ? rev8(rx_msb) : rx_msb;
   assign rd_word = regs[rx_byte[3:0]];
   assign tx_load = LSB_FIRST ? rev8(rd_word) : rd_word;

   always_ff @(posedge i_ck or negedge i_rstn) begin
      if (!i_rstn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      clear     = 1'b0;
      shift_en  = 1'b0;
      cmd_done  = 1'b0;
      data_done = 1'b0;
      tx_en     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (csn_fall) begin
               state_d = S_CMD;
               clear   = 1'b1;
            end
         end
         S_CMD: begin
            if (sclk_rise) begin
               shift_en = 1'b1;
               if (bit_cnt == 3'd7) begin
                  cmd_done = 1'b1;
                  state_d  = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (sclk_fall && cmd_rw) tx_en = 1'b1;
            if (sclk_rise) begin
               shift_en = 1'b1;
               if (bit_cnt == 3'd7) begin
                  data_done = 1'b1;
                  state_d   = S_DONE;
               end
            end
         end
         S_DONE: ;
         default: state_d = S_IDLE;
      endcase
      // Deselect aborts whatever is in flight; nothing partial may commit.
      if (csn_s2 && state_q != S_IDLE) begin
         state_d   = S_IDLE;
         clear     = 1'b0;
         shift_en  = 1'b0;
         cmd_done  = 1'b0;
         data_done = 1'b0;
         tx_en     = 1'b0;
      end
   end

   assign spi_wr = data_done & ~cmd_rw;

   always_ff @(posedge i_ck or negedge i_rstn) begin
      if (!i_rstn) begin
         bit_cnt       <= '0;
         rx_shift      <= '0;
         tx_shift      <= '0;
         cmd_rw        <= 1'b0;
         cmd_idx       <= '0;
         miso_q        <= 1'b0;
         oe_q          <= 1'b0;
         data_q        <= '0;
         spi_wr_q      <= 1'b0;
         spi_wr_addr_q <= '0;
      end else begin
         if (clear) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
         end else if (shift_en) begin
            bit_cnt  <= bit_cnt + 3'd1;
            rx_shift <= rx_msb[6:0];
         end

         if (clear) begin
            cmd_rw  <= 1'b0;
            cmd_idx <= '0;
         end else if (cmd_done) begin
            cmd_rw  <= rx_byte[7];
            cmd_idx <= rx_byte[3:0];
         end

         if (clear)         tx_shift <= '0;
         else if (cmd_done) tx_shift <= rx_byte[7] ? tx_load : 8'h00;
         else if (tx_en)    tx_shift <= {tx_shift[6:0], 1'b0};

         if (tx_en)                  miso_q <= tx_shift[7];
         else if (state_q != S_DATA) miso_q <= 1'b0;

         oe_q     <= ~csn_s2;
         spi_wr_q <= spi_wr;
         if (spi_wr)     spi_wr_addr_q <= cmd_idx;
         if (bus.i_rd)   data_q        <= regs[bus.i_address];
      end
   end

   // SPI commit is applied after the local write so it wins on an index collision.
   always_ff @(posedge i_ck or negedge i_rstn) begin
      if (!i_rstn) begin
         for (int k = 0; k < 16; k++) regs[k] <= '0;
      end else begin
         if (bus.i_wr) regs[bus.i_address] <= bus.i_data;
         if (spi_wr)   regs[cmd_idx]       <= rx_byte;
      end
   end

   assign bus.o_miso        = miso_q;
   assign bus.o_miso_oe     = oe_q;
   assign bus.o_data        = data_q;
   assign bus.o_spi_wr      = spi_wr_q;
   assign bus.o_spi_wr_addr = spi_wr_addr_q;

endmodule
